// File: rtl/wra_layer_sequencer.sv
// rtl/wra_layer_sequencer.sv - per-layer descriptor sequencer: latches config, streams weights into RAM, kicks datapath
module wra_layer_sequencer #(
    parameter  int MAX_LAYERS = 4,
    parameter  int ADDR_W     = 12,
    parameter  int DATA_W     = 512,
    localparam int CFG_W      = ADDR_W + 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_idx,
    input  logic [CFG_W-1:0]  cfg_data,
    input  logic              start,
    input  logic [4:0]        num_layers,
    input  logic              abort,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    output logic              wgt_we,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic [DATA_W-1:0] wgt_d,
    input  logic              layer_finish,
    output logic              inputbstart_op,
    output logic [4:0]        numswitchH_op,
    output logic [8:0]        numslideH_op,
    output logic [4:0]        numslideV_op,
    output logic [4:0]        NInch_D_PInch_op,
    output logic [4:0]        NOuch_D_POuch_op,
    output logic              poolingen_op,
    output logic              padding_op,
    output logic              relu_op,
    output logic [1:0]        fixpoint_op,
    output logic              kernelsize_op,
    output logic              stride_op,
    output logic [3:0]        layer_idx,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOAD_W, S_KICK, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          layer_idx_q, layer_idx_d;
    logic [4:0]          nl_q, nl_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   load_last_q, load_last_d;
    logic                wgt_we_q, wgt_we_d;
    logic [ADDR_W-1:0]   wgt_addr_q, wgt_addr_d;
    logic [DATA_W-1:0]   wgt_d_q, wgt_d_d;
    logic                cfg_err_q, cfg_err_d;
    logic [35:0]         op_cfg_q, op_cfg_d;
    logic [CFG_W-1:0]    table_q [MAX_LAYERS];
    logic [CFG_W-1:0]    table_d [MAX_LAYERS];
    logic [CFG_W-1:0]    cur_cfg;
    logic                cfg_ok;

    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        nl_d        = nl_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        load_last_d = load_last_q;
        wgt_we_d    = 1'b0;
        wgt_addr_d  = wgt_addr_q;
        wgt_d_d     = wgt_d_q;
        op_cfg_d    = op_cfg_q;
        table_d     = table_q;
        cur_cfg     = '0;

        for (int i = 0; i < MAX_LAYERS; i++) begin
            if (layer_idx_q == 4'(i)) cur_cfg = table_q[i];
        end

        // Table is only writable while idle and in range; everything else is flagged.
        cfg_ok    = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_idx} < 5'(MAX_LAYERS));
        cfg_err_d = cfg_we && !cfg_ok;
        for (int i = 0; i < MAX_LAYERS; i++) begin
            if (cfg_ok && cfg_idx == 4'(i)) table_d[i] = cfg_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_layers != 5'd0 && num_layers <= 5'(MAX_LAYERS)) begin
                        layer_idx_d = 4'd0;
                        busy_d      = 1'b1;
                        nl_d        = num_layers;
                        state_d     = S_LATCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LATCH: begin
                op_cfg_d    = cur_cfg[CFG_W-1:ADDR_W];
                load_last_d = cur_cfg[ADDR_W-1:0];
                cnt_d       = '0;
                state_d     = S_LOAD_W;
            end
            S_LOAD_W: begin
                if (w_valid) begin
                    wgt_we_d   = 1'b1;
                    wgt_addr_d = cnt_q;
                    wgt_d_d    = w_data;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == load_last_q) state_d = S_KICK;
                end
            end
            S_KICK: state_d = S_RUN;
            S_RUN: begin
                if (layer_finish) begin
                    if ({1'b0, layer_idx_q} == nl_q - 5'd1) begin
                        state_d = S_DONE;
                    end else begin
                        layer_idx_d = layer_idx_q + 4'd1;
                        state_d     = S_LATCH;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort outranks layer_finish and suppresses the pending RAM write.
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            wgt_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            layer_idx_q <= '0;
            nl_q        <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            load_last_q <= '0;
            wgt_we_q    <= 1'b0;
            wgt_addr_q  <= '0;
            wgt_d_q     <= '0;
            cfg_err_q   <= 1'b0;
            op_cfg_q    <= '0;
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            nl_q        <= nl_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            load_last_q <= load_last_d;
            wgt_we_q    <= wgt_we_d;
            wgt_addr_q  <= wgt_addr_d;
            wgt_d_q     <= wgt_d_d;
            cfg_err_q   <= cfg_err_d;
            op_cfg_q    <= op_cfg_d;
        end
    end

    // Descriptor storage survives reset by design.
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    assign w_ready          = (state_q == S_LOAD_W);
    assign inputbstart_op   = (state_q == S_KICK);
    assign done             = (state_q == S_DONE);
    assign busy             = busy_q;
    assign layer_idx        = layer_idx_q;
    assign cfg_err          = cfg_err_q;
    assign wgt_we           = wgt_we_q;
    assign wgt_addr         = wgt_addr_q;
    assign wgt_d            = wgt_d_q;
    assign numswitchH_op    = op_cfg_q[4:0];
    assign numslideH_op     = op_cfg_q[13:5];
    assign numslideV_op     = op_cfg_q[18:14];
    assign NInch_D_PInch_op = op_cfg_q[23:19];
    assign NOuch_D_POuch_op = op_cfg_q[28:24];
    assign poolingen_op     = op_cfg_q[29];
    assign padding_op       = op_cfg_q[30];
    assign relu_op          = op_cfg_q[31];
    assign fixpoint_op      = op_cfg_q[33:32];
    assign kernelsize_op    = op_cfg_q[34];
    assign stride_op        = op_cfg_q[35];
endmodule

// File: tb/tb_wra_layer_sequencer.sv
// tb/tb_wra_layer_sequencer.sv - directed self-checking bench for wra_layer_sequencer
module tb_wra_layer_sequencer;
    localparam int A = 12;
    localparam int D = 32;
    localparam int W = A + 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, cfg_we = 1'b0, start = 1'b0, abort = 1'b0, w_valid = 1'b0, layer_finish = 1'b0;
    logic [3:0] cfg_idx = '0;
    logic [W-1:0] cfg_data = '0;
    logic [4:0] num_layers = '0;
    logic [D-1:0] w_data = '0;
    logic w_ready, wgt_we, inputbstart_op, poolingen_op, padding_op, relu_op, kernelsize_op, stride_op;
    logic busy, done, cfg_err;
    logic [A-1:0] wgt_addr;
    logic [D-1:0] wgt_d;
    logic [4:0] numswitchH_op, numslideV_op, NInch_D_PInch_op, NOuch_D_POuch_op;
    logic [8:0] numslideH_op;
    logic [1:0] fixpoint_op;
    logic [3:0] layer_idx;

    wra_layer_sequencer #(.MAX_LAYERS(4), .ADDR_W(A), .DATA_W(D)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .start(start), .num_layers(num_layers), .abort(abort),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_d(wgt_d),
        .layer_finish(layer_finish), .inputbstart_op(inputbstart_op),
        .numswitchH_op(numswitchH_op), .numslideH_op(numslideH_op), .numslideV_op(numslideV_op),
        .NInch_D_PInch_op(NInch_D_PInch_op), .NOuch_D_POuch_op(NOuch_D_POuch_op),
        .poolingen_op(poolingen_op), .padding_op(padding_op), .relu_op(relu_op),
        .fixpoint_op(fixpoint_op), .kernelsize_op(kernelsize_op), .stride_op(stride_op),
        .layer_idx(layer_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write/kick/done observer, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [A-1:0] wa_q[$];
    logic [D-1:0] wd_q[$];
    int wc_q[$];
    int kicks = 0, kick_we = 0, dones = 0;
    always @(negedge clk) begin
        if (wgt_we) begin
            wa_q.push_back(wgt_addr);
            wd_q.push_back(wgt_d);
            wc_q.push_back(cyc);
        end
        if (inputbstart_op) begin
            kicks++;
            if (wgt_we) kick_we++;
        end
        if (done) dones++;
    end

    function automatic logic [W-1:0] mk(int ll, int nsw, int nslh, int nslv, int ninch, int nouch,
                                        int pool, int pad, int relu, int fix, int ks, int st);
        return {1'(st), 1'(ks), 2'(fix), 1'(relu), 1'(pad), 1'(pool), 5'(nouch), 5'(ninch),
                5'(nslv), 9'(nslh), 5'(nsw), 12'(ll)};
    endfunction

    function automatic logic [35:0] ops();
        return {stride_op, kernelsize_op, fixpoint_op, relu_op, padding_op, poolingen_op,
                NOuch_D_POuch_op, NInch_D_PInch_op, numslideV_op, numslideH_op, numswitchH_op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cfg(input int idx, input logic [W-1:0] d);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    logic [D-1:0] exp_d[$];

    task automatic feed(input int n, input bit rnd, output int sent);
        sent = 0;
        for (int c = 0; c < 4000 && sent < n; c++) begin
            w_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            w_data  = $urandom;
            if (w_valid && w_ready) begin
                exp_d.push_back(w_data);
                sent++;
            end
            tick();
        end
        w_valid = 1'b0;
    endtask

    // Streams one layer's weights and checks the write trace, kick and latched config.
    task automatic run_layer(input string nm, input int n, input bit rnd, input logic [W-1:0] desc,
                             input int li, input bit last);
        int base, sent, bad, k0;
        base = wa_q.size();
        k0 = kick_we;
        exp_d.delete();
        feed(n, rnd, sent);
        check({nm, "_sent"}, 64'(sent), 64'(n));
        check({nm, "_kick"}, 64'(inputbstart_op), 64'd1);
        tick();
        check({nm, "_kick_with_last_we"}, 64'(kick_we - k0), 64'd1);
        check({nm, "_wcount"}, 64'(wa_q.size() - base), 64'(n));
        bad = 0;
        for (int i = 0; i < n && base + i < wa_q.size(); i++) begin
            if (wa_q[base + i] != A'(i) || wd_q[base + i] != exp_d[i]) bad++;
        end
        check({nm, "_addr_data_seq"}, 64'(bad), 64'd0);
        if (!rnd)
            check({nm, "_back_to_back"}, 64'(wc_q[wa_q.size() - 1] - wc_q[base]), 64'(n - 1));
        check({nm, "_ops"}, 64'(ops()), 64'(desc[W-1:A]));
        check({nm, "_layer_idx"}, 64'(layer_idx), 64'(li));
        check({nm, "_busy_run"}, 64'(busy), 64'd1);
        layer_finish = 1'b1;
        tick();
        layer_finish = 1'b0;
        check({nm, "_done_after_finish"}, 64'(done), 64'(last));
        if (last) begin
            tick();
            check({nm, "_done_one_cycle"}, 64'(done), 64'd0);
            check({nm, "_busy_clear"}, 64'(busy), 64'd0);
        end
    endtask

    logic [W-1:0] d0, d1, d2, d3, junk;
    int sent, dn, kk, nw;

    initial begin
        d0   = mk(195, 3, 12, 7, 4, 8, 0, 1, 1, 2, 1, 0);
        d1   = mk(31, 5, 12, 6, 2, 2, 0, 0, 1, 1, 0, 1);
        d2   = mk(159, 17, 10, 9, 16, 31, 1, 1, 0, 3, 1, 1);
        d3   = mk(31, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        junk = mk(7, 31, 511, 31, 31, 31, 1, 1, 1, 3, 1, 1);

        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_w_ready", 64'(w_ready), 64'd0);
        check("rst_wgt_we", 64'(wgt_we), 64'd0);
        check("rst_wgt_addr", 64'(wgt_addr), 64'd0);
        check("rst_ops", 64'(ops()), 64'd0);
        check("rst_layer_idx", 64'(layer_idx), 64'd0);
        rst = 1'b0;
        tick();

        wr_cfg(0, d3);
        check("cfg_ok_no_err", 64'(cfg_err), 64'd0);
        wr_cfg(5, junk);
        check("cfg_oob_err", 64'(cfg_err), 64'd1);
        tick();
        check("cfg_err_pulse", 64'(cfg_err), 64'd0);

        // Single layer, valid held high.
        dn = dones;
        start = 1'b1; num_layers = 5'd1;
        tick();
        start = 1'b0;
        check("t1_busy_latch", 64'(busy), 64'd1);
        run_layer("t1", 32, 1'b0, d3, 0, 1'b1);
        check("t1_done_count", 64'(dones - dn), 64'd1);

        // Three layers; illegal write and restart attempted while busy.
        wr_cfg(0, d0); wr_cfg(1, d1); wr_cfg(2, d2);
        dn = dones;
        start = 1'b1; num_layers = 5'd3;
        tick();
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_data = junk; start = 1'b1; num_layers = 5'd1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        check("busy_cfg_err", 64'(cfg_err), 64'd1);
        run_layer("t2_l0", 196, 1'b0, d0, 0, 1'b0);
        check("t2_numslideH_l0", 64'(numslideH_op), 64'd12);
        run_layer("t2_l1", 32, 1'b1, d1, 1, 1'b0);
        run_layer("t2_l2", 160, 1'b1, d2, 2, 1'b1);
        check("t2_numslideH_l2", 64'(numslideH_op), 64'd10);
        check("t2_pool_l2", 64'(poolingen_op), 64'd1);
        check("t2_layer_idx_hold", 64'(layer_idx), 64'd2);
        check("t2_done_count", 64'(dones - dn), 64'd1);

        // Abort after 10 writes, with a handshake pending in the abort cycle.
        dn = dones;
        nw = wa_q.size();
        start = 1'b1; num_layers = 5'd1;
        tick();
        start = 1'b0;
        exp_d.delete();
        feed(10, 1'b0, sent);
        w_valid = 1'b1; abort = 1'b1;
        tick();
        w_valid = 1'b0; abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_w_ready", 64'(w_ready), 64'd0);
        tick();
        check("abort_wgt_we", 64'(wgt_we), 64'd0);
        check("abort_wcount", 64'(wa_q.size() - nw), 64'd10);
        repeat (3) tick();
        check("abort_no_done", 64'(dones - dn), 64'd0);
        start = 1'b1; num_layers = 5'd1;
        tick();
        start = 1'b0;
        run_layer("rerun", 196, 1'b0, d0, 0, 1'b1);

        // Empty and oversize runs complete immediately.
        nw = wa_q.size(); kk = kicks;
        start = 1'b1; num_layers = 5'd0;
        tick();
        start = 1'b0;
        check("nl0_done", 64'(done), 64'd1);
        tick();
        check("nl0_done_pulse", 64'(done), 64'd0);
        start = 1'b1; num_layers = 5'd5;
        tick();
        start = 1'b0;
        check("nl5_done", 64'(done), 64'd1);
        tick();
        check("nl_bad_no_we", 64'(wa_q.size() - nw), 64'd0);
        check("nl_bad_no_kick", 64'(kicks - kk), 64'd0);

        // Reset mid-run behaves like abort and clears outputs.
        dn = dones;
        start = 1'b1; num_layers = 5'd2;
        tick();
        start = 1'b0;
        feed(5, 1'b0, sent);
        rst = 1'b1; layer_finish = 1'b1;
        tick();
        rst = 1'b0; layer_finish = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ops", 64'(ops()), 64'd0);
        check("rst_mid_addr", 64'(wgt_addr), 64'd0);
        check("rst_mid_w_ready", 64'(w_ready), 64'd0);
        repeat (3) tick();
        check("rst_mid_no_done", 64'(dones - dn), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wra_layer_sequencer.md
WRA_LAYER_SEQUENCER -- requirements
Module: wra_layer_sequencer

Interface
REQ-001 Parameter MAX_LAYERS, default 4: descriptor table depth (supported range 1-16).
REQ-002 Parameter ADDR_W, default 12: weight RAM address width.
REQ-003 Parameter DATA_W, default 512: weight word width.
REQ-004 Parameter CFG_W, fixed at ADDR_W+36: descriptor width.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_we  in  1  descriptor write strobe.
REQ-008 cfg_idx  in  4  descriptor index.
REQ-009 cfg_data  in  CFG_W  descriptor word, LSB-first fields: load_last[ADDR_W], numswitchH[5], numslideH[9], numslideV[5], NInch_D_PInch[5], NOuch_D_POuch[5], poolingen[1], padding[1], relu[1], fixpoint[2], kernelsize[1], stride[1].
REQ-010 start  in  1  begin a run of num_layers layers.
REQ-011 num_layers  in  5  layers in the run (0..MAX_LAYERS).
REQ-012 abort  in  1  cancel the run.
REQ-013 w_valid / w_data  in  1 / DATA_W  weight stream.
REQ-014 w_ready  out  1  weight stream accept.
REQ-015 wgt_we / wgt_addr / wgt_d  out  1 / ADDR_W / DATA_W  weight RAM write port.
REQ-016 layer_finish  in  1  end-of-layer pulse from the datapath.
REQ-017 inputbstart_op  out  1  layer start pulse to the datapath.
REQ-018 numswitchH_op, numslideH_op, numslideV_op, NInch_D_PInch_op, NOuch_D_POuch_op, poolingen_op, padding_op, relu_op, fixpoint_op, kernelsize_op, stride_op  out  field widths  current-layer configuration.
REQ-019 layer_idx  out  4  current layer index; busy  out  1; done  out  1  run-complete pulse; cfg_err  out  1  rejected-write pulse.

Function
REQ-020 States: IDLE, LATCH, LOAD_W, KICK, RUN, DONE.
REQ-021 IDLE: cfg_we writes cfg_data to table[cfg_idx]; writes with cfg_idx>=MAX_LAYERS are dropped and pulse cfg_err.
REQ-022 Any cfg_we while busy=1 is dropped, the table is unchanged, and cfg_err pulses for one cycle.
REQ-023 start in IDLE with num_layers in 1..MAX_LAYERS: layer_idx<=0, busy<=1, go to LATCH.
REQ-024 start in IDLE with num_layers==0 or >MAX_LAYERS: no layer runs; done pulses the following cycle.
REQ-025 start while busy is ignored.
REQ-026 LATCH (1 cycle): all *_op config outputs load from table[layer_idx]; weight counter<=0; go to LOAD_W.
REQ-027 Config outputs hold stable from LATCH until the next LATCH or reset.
REQ-028 LOAD_W: w_ready=1. Each cycle with w_valid=1 produces, on the next cycle, wgt_we=1, wgt_addr=counter and wgt_d=w_data (1-cycle latency); counter then increments.
REQ-029 w_valid=0 gaps stall LOAD_W with no write and no counter change.
REQ-030 The handshake with counter==load_last is the final write of LOAD_W; the next state is KICK, and w_ready=0 from that point on.
REQ-031 KICK (1 cycle): inputbstart_op=1. KICK coincides with the final wgt_we; next state is RUN.
REQ-032 RUN: wait for layer_finish. On layer_finish, if layer_idx==num_layers-1 go to DONE; otherwise increment layer_idx and go to LATCH.
REQ-033 layer_finish outside RUN is ignored.
REQ-034 DONE (1 cycle): done=1, busy<=0, then IDLE; layer_idx holds its last value.
REQ-035 abort in any non-IDLE state: next cycle is IDLE, busy=0, w_ready=0, wgt_we=0, no done pulse; the table is preserved.
REQ-036 abort and layer_finish in the same cycle: abort wins.
REQ-037 num_layers is sampled at start; later changes have no effect on the run.

Reset
REQ-038 rst=1: state IDLE; every output is 0, including all *_op outputs, layer_idx, wgt_addr and wgt_d; the weight counter is cleared.
REQ-039 rst does not clear the descriptor table (its contents are undefined after power-up).
REQ-040 rst mid-run takes effect the next cycle, with the same result as abort, and overrides all other inputs.

Verification
REQ-041 One layer, load_last=31, w_valid held high -> 32 writes to addresses 0..31 on consecutive cycles, inputbstart_op pulse in the last-write cycle, done pulse 1 cycle after layer_finish.
REQ-042 Three layers with load_last 195/31/159, numslideH 12/12/10, poolingen 0/0/1 -> per-layer write counts 196/32/160, each *_op equal to its descriptor from LATCH through RUN, layer_idx 0->1->2.
REQ-043 w_valid toggled pseudo-randomly during LOAD_W -> write addresses contiguous with no gaps or duplicates, and wgt_d equals the accepted w_data in order.
REQ-044 abort after 10 writes, then start again -> IDLE next cycle, no done pulse; the rerun restarts at address 0 with an intact table.
REQ-045 cfg_we and start asserted while busy -> cfg_err pulses, table unchanged, current run unaffected.
REQ-046 start with num_layers=0 -> no wgt_we and no inputbstart_op; done pulses 1 cycle later.
